// File: rtl/rr_arb_mux_nbits.sv
// rr_arb_mux_nbits: N_CH-way, WIDTH-bit registered multiplexer with a one-word
// output register. A channel is chosen either by round-robin arbitration among
// the valid channels or by a fixed select index.
//
// Handshake semantics: a word moves across an interface on a rising edge where
// valid and ready are both 1 on that interface. On the input side in_ready is
// combinational, one-hot or zero. It is only raised for a channel that is already
// valid, so producers may change in_valid freely while their ready is 0. On the
// output side out_valid/out_data/out_sel are registered and hold stable while
// out_ready is 0. The register can load in the same cycle that it drains, which
// gives one word per cycle.
module rr_arb_mux_nbits #(
    parameter  int N_CH  = 32,
    parameter  int WIDTH = 32,
    localparam int SELW  = $clog2(N_CH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fixed_mode,
    input  logic [SELW-1:0]       select,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    // The output register is either empty or holds one word; out_valid is the state.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SELW-1:0] last_grant;
    logic            can_load;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic            sel_oor;

    // The register may load when empty or when its current word leaves this cycle.
    assign can_load = (state == EMPTY) || out_ready;

    // Out-of-range select only happens when N_CH is not a power of two.
    assign sel_oor = (int'(select) >= N_CH);

    // Grant selection: the fixed index, or the first valid channel after last_grant with wrap at N_CH.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (can_load) begin
            if (fixed_mode) begin
                if (!sel_oor) begin
                    if (in_valid[select]) begin
                        grant_vld = 1'b1;
                        grant_idx = select;
                    end
                end
            end else begin
                for (int k = 1; k <= N_CH; k++) begin
                    idx = int'(last_grant) + k;
                    if (idx >= N_CH) begin
                        idx = idx - N_CH;
                    end
                    if (!grant_vld && in_valid[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = SELW'(idx);
                    end
                end
            end
        end
    end

    // Ready goes only to the granted channel. A grant implies valid, so a grant is a transfer.
    always_comb begin
        in_ready = '0;
        if (grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next state: a transfer always fills the register; otherwise a full register drains on out_ready.
    always_comb begin
        state_nx = state;
        if (grant_vld) begin
            state_nx = FULL;
        end else if (state == FULL && out_ready) begin
            state_nx = EMPTY;
        end
    end

    assign out_valid = (state == FULL);

    // State, output register, round-robin pointer and the select-error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_sel    <= '0;
            sel_err    <= 1'b0;
            last_grant <= SELW'(N_CH - 1);
        end else begin
            state   <= state_nx;
            sel_err <= fixed_mode && sel_oor && (|in_valid);
            if (grant_vld) begin
                out_data   <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_sel    <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_nbits.sv
// Directed bench for rr_arb_mux_nbits. It uses a 32-channel instance and a
// 5-channel instance so that the wrap at N_CH, rather than at 2^SELW, is exercised.
module tb_rr_arb_mux_nbits;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 32-channel instance
    logic           fixed_mode;
    logic [4:0]     select;
    logic [1023:0]  in_data;
    logic [31:0]    in_valid;
    logic [31:0]    in_ready;
    logic [31:0]    out_data;
    logic [4:0]     out_sel;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;

    // 5-channel instance
    logic           s_fixed_mode;
    logic [2:0]     s_select;
    logic [159:0]   s_in_data;
    logic [4:0]     s_in_valid;
    logic [4:0]     s_in_ready;
    logic [31:0]    s_out_data;
    logic [2:0]     s_out_sel;
    logic           s_out_valid;
    logic           s_out_ready;
    logic           s_sel_err;

    rr_arb_mux_nbits #(.N_CH(32), .WIDTH(32)) dut (
        .clock(clock), .reset(reset), .fixed_mode(fixed_mode), .select(select),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    rr_arb_mux_nbits #(.N_CH(5), .WIDTH(32)) dut5 (
        .clock(clock), .reset(reset), .fixed_mode(s_fixed_mode), .select(s_select),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sel_err(s_sel_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard for the 5-channel random run: {sel, data}.
    logic [34:0] exp_q[$];
    logic        pending [5];
    logic [31:0] pdata   [5];
    int          wait_cnt[5];
    int          word_id = 0;

    // ---------------- driver tasks ----------------
    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++; if (out_sel !== 5'd0) begin n_fail++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
        n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%0b exp=0", sel_err); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset5_out_valid got=%0b exp=0", s_out_valid); end
        n_checks++; if (in_ready !== 32'h0) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=0", in_ready); end
    endtask

    task automatic test_rr_sweep();
        do_reset();
        fixed_mode = 1'b0;
        in_valid   = 32'hFFFF_FFFF;
        out_ready  = 1'b1;
        #1;
        n_checks++; if (in_ready !== 32'h0000_0001) begin n_fail++; $display("FAIL sweep_first_ready got=%h exp=00000001", in_ready); end
        for (int i = 0; i <= 32; i++) begin
            step();
            n_checks++; if (out_sel !== 5'(i % 32)) begin n_fail++; $display("FAIL sweep_sel[%0d] got=%0d exp=%0d", i, out_sel, i % 32); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d] got=%0b exp=1", i, out_valid); end
            n_checks++; if (out_data !== 32'hA500_0000 + 32'(i % 32)) begin n_fail++; $display("FAIL sweep_data[%0d] got=%h exp=%h", i, out_data, 32'hA500_0000 + 32'(i % 32)); end
        end
    endtask

    task automatic test_fixed();
        do_reset();
        in_data[5*32 +: 32] = 32'hDEAD_BEEF;
        fixed_mode = 1'b1;
        select     = 5'd5;
        in_valid   = 32'h0000_0020;
        out_ready  = 1'b1;
        #1;
        n_checks++; if (in_ready !== 32'h0000_0020) begin n_fail++; $display("FAIL fixed_ready got=%h exp=00000020", in_ready); end
        step();
        n_checks++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fixed_data got=%h exp=deadbeef", out_data); end
        n_checks++; if (out_sel !== 5'd5) begin n_fail++; $display("FAIL fixed_sel got=%0d exp=5", out_sel); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_valid got=%0b exp=1", out_valid); end
    endtask

    // Continues from test_fixed: register FULL with channel 5, last grant 5.
    task automatic test_stall();
        out_ready  = 1'b0;
        fixed_mode = 1'b0;
        in_valid   = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 32'h0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%h exp=0", i, in_ready); end
            step();
            n_checks++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=deadbeef", i, out_data); end
            n_checks++; if (out_sel !== 5'd5) begin n_fail++; $display("FAIL stall_sel[%0d] got=%0d exp=5", i, out_sel); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%0b exp=1", i, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 32'h0000_0040) begin n_fail++; $display("FAIL release_ready got=%h exp=00000040", in_ready); end
        step();
        n_checks++; if (out_sel !== 5'd6) begin n_fail++; $display("FAIL release_sel got=%0d exp=6", out_sel); end
        n_checks++; if (out_data !== 32'hA500_0006) begin n_fail++; $display("FAIL release_data got=%h exp=a5000006", out_data); end
    endtask

    // Continues from test_stall: register FULL with channel 6.
    task automatic test_reset_full();
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rstfull_data got=%h exp=0", out_data); end
        n_checks++; if (out_sel !== 5'd0) begin n_fail++; $display("FAIL rstfull_sel got=%0d exp=0", out_sel); end
        reset     = 1'b0;
        in_valid  = 32'h0000_0300;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 32'h0000_0100) begin n_fail++; $display("FAIL rstfull_ready got=%h exp=00000100", in_ready); end
        step();
        n_checks++; if (out_sel !== 5'd8) begin n_fail++; $display("FAIL rstfull_grant got=%0d exp=8", out_sel); end
        n_checks++; if (out_data !== 32'hA500_0008) begin n_fail++; $display("FAIL rstfull_gdata got=%h exp=a5000008", out_data); end
        in_valid = 32'h0;
    endtask

    task automatic test_nonpow2();
        int exp_seq[3] = '{0, 4, 0};
        do_reset();
        for (int i = 0; i < 5; i++) s_in_data[i*32 +: 32] = 32'h5000_0000 + 32'(i);
        s_out_ready  = 1'b1;
        s_fixed_mode = 1'b1;
        s_select     = 3'd4;
        s_in_valid   = 5'b10001;
        #1;
        n_checks++; if (s_in_ready !== 5'b10000) begin n_fail++; $display("FAIL np2_fixed_ready got=%b exp=10000", s_in_ready); end
        step();
        n_checks++; if (s_out_sel !== 3'd4) begin n_fail++; $display("FAIL np2_fixed_sel got=%0d exp=4", s_out_sel); end
        s_fixed_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (s_out_sel !== 3'(exp_seq[i])) begin n_fail++; $display("FAIL np2_wrap[%0d] got=%0d exp=%0d", i, s_out_sel, exp_seq[i]); end
            n_checks++; if (s_out_data !== 32'h5000_0000 + 32'(exp_seq[i])) begin n_fail++; $display("FAIL np2_data[%0d] got=%h exp=%h", i, s_out_data, 32'h5000_0000 + 32'(exp_seq[i])); end
        end
        s_fixed_mode = 1'b1;
        s_select     = 3'd5;
        #1;
        n_checks++; if (s_in_ready !== 5'b0) begin n_fail++; $display("FAIL np2_sel5_ready got=%b exp=00000", s_in_ready); end
        s_select = 3'd6;
        #1;
        n_checks++; if (s_in_ready !== 5'b0) begin n_fail++; $display("FAIL np2_sel6_ready got=%b exp=00000", s_in_ready); end
        step();
        n_checks++; if (s_sel_err !== 1'b1) begin n_fail++; $display("FAIL np2_sel_err got=%0b exp=1", s_sel_err); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL np2_drain got=%0b exp=0", s_out_valid); end
        s_fixed_mode = 1'b0;
        s_in_valid   = 5'b0;
        step();
        n_checks++; if (s_sel_err !== 1'b0) begin n_fail++; $display("FAIL np2_sel_err_pulse got=%0b exp=0", s_sel_err); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL np2_idle got=%0b exp=0", s_out_valid); end
    endtask

    // One random cycle on the 5-channel instance; producers hold a word until it is taken.
    task automatic rand_cycle(input bit gen, input bit drain);
        logic can_load;
        int   g;
        for (int c = 0; c < 5; c++) begin
            if (gen && !pending[c] && $urandom_range(1, 0) == 1) begin
                pending[c] = 1'b1;
                pdata[c]   = 32'h7000_0000 + 32'(word_id);
                word_id++;
            end
            s_in_valid[c]         = pending[c];
            s_in_data[c*32 +: 32] = pdata[c];
        end
        s_out_ready = drain ? 1'b1 : ($urandom_range(3, 0) != 0);
        #1;
        n_checks++; if ((s_in_ready & (s_in_ready - 5'd1)) !== 5'b0 || (s_in_ready & ~s_in_valid) !== 5'b0) begin
            n_fail++; $display("FAIL rnd_ready_shape got=%b valid=%b", s_in_ready, s_in_valid);
        end
        can_load = !s_out_valid || s_out_ready;
        n_checks++; if ((|s_in_ready) !== (can_load && (|s_in_valid))) begin
            n_fail++; $display("FAIL rnd_work_conserving got=%b exp_any=%0b", s_in_ready, can_load && (|s_in_valid));
        end
        if (s_out_valid && s_out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rnd_extra_word got=%0d:%h exp=none", s_out_sel, s_out_data);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                if ({s_out_sel, s_out_data} !== e) begin
                    n_fail++; $display("FAIL rnd_word got=%0d:%h exp=%0d:%h", s_out_sel, s_out_data, e[34:32], e[31:0]);
                end
            end
        end
        g = -1;
        for (int c = 0; c < 5; c++) if (s_in_ready[c]) g = c;
        if (g >= 0) begin
            exp_q.push_back({3'(g), pdata[g]});
            for (int c = 0; c < 5; c++) begin
                if (c != g && pending[c]) begin
                    wait_cnt[c]++;
                    n_checks++; if (wait_cnt[c] > 4) begin n_fail++; $display("FAIL rnd_starve ch=%0d got=%0d exp<=4", c, wait_cnt[c]); end
                end
            end
            wait_cnt[g] = 0;
            pending[g]  = 1'b0;
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        s_fixed_mode = 1'b0;
        s_select     = 3'd0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            pending[c] = 1'b0; pdata[c] = 32'h0; wait_cnt[c] = 0;
        end
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) rand_cycle(1'b0, 1'b1);
        n_checks++; if (exp_q.size() != 0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_final_drain got_q=%0d got_valid=%0b exp=0/0", exp_q.size(), s_out_valid);
        end
        s_in_valid = 5'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        fixed_mode   = 1'b0;
        select       = 5'd0;
        in_valid     = 32'h0;
        out_ready    = 1'b0;
        s_fixed_mode = 1'b0;
        s_select     = 3'd0;
        s_in_valid   = 5'b0;
        s_out_ready  = 1'b0;
        s_in_data    = '0;
        for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = 32'hA500_0000 + 32'(i);

        test_reset();
        test_rr_sweep();
        test_fixed();
        test_stall();
        test_reset_full();
        test_nonpow2();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
